// File: rtl/logic_arbiter_if.sv
// Bus bundle between two requesters, the shared logic unit and the response consumer.
// master: arbiter side. slave: environment side (requesters, logic unit, consumer).
interface logic_arbiter_if #(
  parameter int N = 4
);
  logic         req0_valid, req0_ready;
  logic         req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_sel, req1_sel;
  logic [N-1:0] lu_a, lu_b, lu_result;
  logic [1:0]   lu_select;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_result;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req0_ready, req1_ready,
    output lu_a, lu_b, lu_select,
    input  lu_result,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req0_ready, req1_ready,
    input  lu_a, lu_b, lu_select,
    output lu_result,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );
endinterface

// File: rtl/logic_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational logic unit.
// One operation in flight: IDLE grants and captures, EXEC registers the unit's
// result, RESP holds the response until the consumer takes it.
module logic_arbiter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  logic_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         gnt0, gnt1;
  logic [N-1:0] cap_a, cap_b;
  logic [1:0]   cap_sel;
  logic         cap_id;
  logic         last;        // last requester served; 1 out of reset so req0 wins first
  logic [N-1:0] res_q;
  logic         id_q;

  // Next state and grant; grants are suppressed while reset is asserted
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          if (bus.req0_valid && (!bus.req1_valid || last)) gnt0 = 1'b1;
          else                                              gnt1 = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the granted requester's operands so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sel <= 2'b00;
      cap_id  <= 1'b0;
    end else if (gnt0 || gnt1) begin
      cap_a   <= gnt1 ? bus.req1_a   : bus.req0_a;
      cap_b   <= gnt1 ? bus.req1_b   : bus.req0_b;
      cap_sel <= gnt1 ? bus.req1_sel : bus.req0_sel;
      cap_id  <= gnt1;
    end
  end

  // Register the unit's result in EXEC; held unchanged through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      id_q  <= 1'b0;
    end else if (state == EXEC) begin
      res_q <= bus.lu_result;
      id_q  <= cap_id;
    end
  end

  // Round-robin pointer advances only when a response is actually consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               last <= 1'b1;
    else if (state == RESP && bus.rsp_ready)  last <= id_q;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.lu_a       = cap_a;
  assign bus.lu_b       = cap_b;
  assign bus.lu_select  = cap_sel;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;

endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter: N, 4, operand/result width in bits (N >= 1).
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
- req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  N  operands for requester 0/1.
- req0_sel / req1_sel  in  2  operation select for requester 0/1: 00 a&b, 01 a|b, 10 a^b, 11 ~a.
- lu_a, lu_b  out  N  operands driven to the shared logic unit.
- lu_select  out  2  select driven to the shared logic unit.
- lu_result  in  N  combinational result from the shared logic unit.
- rsp_valid  out  1  response holds a completed result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response (0 or 1).
- rsp_result  out  N  captured logic unit result.
REQ-003 The block SHALL use one clock with an asynchronous, active-low reset, as stated in REQ-002.

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-005 IDLE: if any reqX_valid, the block SHALL assert exactly one reqX_ready (the grant) combinationally, capture that requester's a, b, sel and id into internal registers, and go to EXEC on the next edge; with no valid it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin on a last-served pointer: if only one requester is valid, it wins; if both are valid, the requester not last served wins.
REQ-007 The last-served pointer SHALL update only when a response completes in RESP (rsp_valid && rsp_ready).
REQ-008 reqX_ready SHALL be 0 in EXEC and RESP; at most one reqX_ready is high in any cycle.
REQ-009 lu_a, lu_b and lu_select SHALL be driven continuously from the captured registers, so they are stable for the whole EXEC cycle.
REQ-010 EXEC: the block SHALL register lu_result into rsp_result and the captured id into rsp_id, and go to RESP after exactly one cycle.
REQ-011 RESP: rsp_valid SHALL be 1, and rsp_result and rsp_id SHALL stay stable until rsp_ready; on rsp_ready the block SHALL go to IDLE with rsp_valid low on the next cycle.
REQ-012 Timing: from handshake edge to rsp_valid high is 2 cycles; peak throughput is one operation per 3 cycles.
REQ-013 Inputs that change after acceptance SHALL NOT affect the operation in flight.
REQ-014 If rsp_ready is held high, the block SHALL still pass through IDLE for one cycle before the next grant; back-pressure SHALL NOT drop or reorder a response.
REQ-015 Results SHALL be exactly N bits; no bits above N-1 are produced.

Reset
REQ-016 When rst_n is low, the block SHALL enter IDLE at once and clear all outputs and registers: rsp_valid=0, rsp_id=0, rsp_result=0, lu_a=0, lu_b=0, lu_select=00, reqX_ready=0.
REQ-017 Reset SHALL set the last-served pointer to 1, so requester 0 wins the first contended grant.
REQ-018 Reset asserted in EXEC or RESP SHALL abort the operation in flight, and its response SHALL never appear.

Verification
REQ-019 The bench SHALL cover at least these scenarios with N=4, a=5, b=6 and rsp_ready=1:
- Single request, req0 only: sel 00 -> result 0100; sel 01 -> 0111; sel 10 -> 0011; sel 11 -> 1010; rsp_id=0 each time, with rsp_valid 2 cycles after accept.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1; rsp_id follows the same order.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_id are stable; no reqX_ready is asserted; completion follows one cycle after rsp_ready rises.
- Operands change to a=0, b=0 during EXEC and RESP -> the response still reflects the captured a=5, b=6.
- rst_n pulsed low during EXEC -> outputs go to reset values at once; no response appears; the next contended grant goes to requester 0.
- The bench SHALL check throughout that req0_ready and req1_ready are never high together.
